// File: rtl/cmp_pkg.sv
// Shared types and elaboration helpers for the sequential magnitude comparator.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // CMP_EQ doubles as "no difference recorded yet" while the compare runs.
    typedef enum logic [1:0] {
        CMP_EQ = 2'd0,
        CMP_LT = 2'd1,
        CMP_GT = 2'd2
    } cmp_t;

    function automatic int num_digits(input int width, input int digit);
        return width / digit;
    endfunction

    function automatic bit width_ok(input int width, input int digit);
        return (digit > 0) && (width >= digit) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/seq_magnitude_comparator_digit_compare.sv
// Combinational compare of one DIGIT-bit slice of each operand.
module digit_compare #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    output logic             lt,
    output logic             gt,
    output logic             eq
);

    assign lt = (x < y);
    assign gt = (x > y);
    assign eq = (x == y);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Digit-serial magnitude comparator: MSB digit first, optional early exit,
// unsigned or two's-complement operands, start/busy/done handshake.
module seq_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DIGIT      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             less,
    output logic             greater,
    output logic             equal
);

    localparam int N    = num_digits(WIDTH, DIGIT);
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0]  IDX_TOP   = IDXW'(N - 1);
    localparam logic [WIDTH-1:0] SIGN_MASK = WIDTH'(1) << (WIDTH - 1);

    if (!width_ok(WIDTH, DIGIT)) begin : g_width_check
        $error("seq_magnitude_comparator: WIDTH must be a non-zero multiple of DIGIT");
    end

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IDXW-1:0]  idx;
    cmp_t             rec;

    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic             dig_lt;
    logic             dig_gt;
    logic             dig_eq;
    logic             first_diff;
    cmp_t             next_rec;

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // Operands are stored in offset-binary when signed, so the sign flip
    // only ever shows up in the top digit and the digit compare stays unsigned.
    assign a_dig = a_q[idx*DIGIT +: DIGIT];
    assign b_dig = b_q[idx*DIGIT +: DIGIT];

    digit_compare #(.DIGIT(DIGIT)) u_digit_compare (
        .x  (a_dig),
        .y  (b_dig),
        .lt (dig_lt),
        .gt (dig_gt),
        .eq (dig_eq)
    );

    // Merge this step's digit result into the recorded result; the first difference wins.
    always_comb begin
        first_diff = 1'b0;
        next_rec   = rec;
        if ((rec == CMP_EQ) && !dig_eq) begin
            first_diff = 1'b1;
            next_rec   = dig_lt ? CMP_LT : (dig_gt ? CMP_GT : CMP_EQ);
        end
    end

    // Control FSM, digit index and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx     <= '0;
            rec     <= CMP_EQ;
            less    <= 1'b0;
            greater <= 1'b0;
            equal   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_q     <= signed_mode ? (a ^ SIGN_MASK) : a;
                        b_q     <= signed_mode ? (b ^ SIGN_MASK) : b;
                        idx     <= IDX_TOP;
                        rec     <= CMP_EQ;
                        less    <= 1'b0;
                        greater <= 1'b0;
                        equal   <= 1'b0;
                        state   <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if ((EARLY_EXIT != 0) && first_diff) begin
                        less    <= (next_rec == CMP_LT);
                        greater <= (next_rec == CMP_GT);
                        state   <= DONE;
                    end else if (idx == '0) begin
                        less    <= (next_rec == CMP_LT);
                        greater <= (next_rec == CMP_GT);
                        equal   <= (next_rec == CMP_EQ);
                        state   <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                        rec <= next_rec;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Scoreboard bench: an early-exit and a fixed-latency comparator side by side.
module tb_seq_magnitude_comparator;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int N     = WIDTH / DIGIT;

    typedef struct {
        logic [2:0] lge;
        int         lat;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start_e = 1'b0;
    logic             start_f = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             signed_mode = 1'b0;

    logic busy_e, done_e, less_e, greater_e, equal_e;
    logic busy_f, done_f, less_f, greater_f, equal_f;

    int total = 0;
    int bad   = 0;

    exp_t q_e[$];
    exp_t q_f[$];
    int   cnt_e = 0;
    int   cnt_f = 0;
    logic have_e = 1'b0;
    logic have_f = 1'b0;
    logic [2:0] last_e = '0;
    logic [2:0] last_f = '0;

    always #5 clk = ~clk;

    seq_magnitude_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT), .EARLY_EXIT(1)) dut_e (
        .clk(clk), .reset(reset), .start(start_e), .a(a), .b(b), .signed_mode(signed_mode),
        .busy(busy_e), .done(done_e), .less(less_e), .greater(greater_e), .equal(equal_e)
    );

    seq_magnitude_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT), .EARLY_EXIT(0)) dut_f (
        .clk(clk), .reset(reset), .start(start_f), .a(a), .b(b), .signed_mode(signed_mode),
        .busy(busy_f), .done(done_f), .less(less_f), .greater(greater_f), .equal(equal_f)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] ref_lge(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                           input logic s);
        logic lt, gt;
        if (s) begin
            lt = $signed(x) < $signed(y);
            gt = $signed(x) > $signed(y);
        end else begin
            lt = x < y;
            gt = x > y;
        end
        return {lt, gt, !(lt || gt)};
    endfunction

    function automatic int ref_lat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] d;
        d = x ^ y;
        for (int j = N - 1; j >= 0; j--) begin
            if (((d >> (j * DIGIT)) & ((1 << DIGIT) - 1)) != 0) return N - j;
        end
        return N;
    endfunction

    task automatic push(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s,
                        input logic ue, input logic uf);
        exp_t t;
        t.lge = ref_lge(x, y, s);
        if (ue) begin
            t.lat = ref_lat(x, y);
            q_e.push_back(t);
        end
        if (uf) begin
            t.lat = N;
            q_f.push_back(t);
        end
    endtask

    task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s,
                         input logic ue, input logic uf);
        @(negedge clk);
        a = x;
        b = y;
        signed_mode = s;
        start_e = ue;
        start_f = uf;
        push(x, y, s, ue, uf);
        @(posedge clk);
        #1;
        start_e = 1'b0;
        start_f = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (q_e.size() == 0 && q_f.size() == 0 && !busy_e && !busy_f && !done_e && !done_f)
                break;
        end
        check("pending_e", q_e.size(), 0);
        check("pending_f", q_f.size(), 0);
    endtask

    // Early-exit DUT monitor: latency, result, zero flags during RUN, hold after done.
    always @(negedge clk) begin
        exp_t x;
        if (reset) begin
            cnt_e  = 0;
            have_e = 1'b0;
        end else if (busy_e) begin
            cnt_e++;
            check("run_flags_e", {less_e, greater_e, equal_e, done_e}, 4'b0000);
        end else if (done_e) begin
            if (q_e.size() == 0) begin
                check("spurious_done_e", 1, 0);
            end else begin
                x = q_e.pop_front();
                check("result_e", {less_e, greater_e, equal_e}, x.lge);
                check("latency_e", cnt_e, x.lat);
                last_e = {less_e, greater_e, equal_e};
                have_e = 1'b1;
            end
            cnt_e = 0;
        end else if (have_e) begin
            check("hold_e", {less_e, greater_e, equal_e}, last_e);
        end
    end

    // Fixed-latency DUT monitor.
    always @(negedge clk) begin
        exp_t x;
        if (reset) begin
            cnt_f  = 0;
            have_f = 1'b0;
        end else if (busy_f) begin
            cnt_f++;
            check("run_flags_f", {less_f, greater_f, equal_f, done_f}, 4'b0000);
        end else if (done_f) begin
            if (q_f.size() == 0) begin
                check("spurious_done_f", 1, 0);
            end else begin
                x = q_f.pop_front();
                check("result_f", {less_f, greater_f, equal_f}, x.lge);
                check("latency_f", cnt_f, x.lat);
                last_f = {less_f, greater_f, equal_f};
                have_f = 1'b1;
            end
            cnt_f = 0;
        end else if (have_f) begin
            check("hold_f", {less_f, greater_f, equal_f}, last_f);
        end
    end

    initial begin
        logic [WIDTH-1:0] ra, rb;
        logic             rs;
        int               guard;

        #3;
        check("reset_outs_e", {busy_e, done_e, less_e, greater_e, equal_e}, 5'b0);
        check("reset_outs_f", {busy_f, done_f, less_f, greater_f, equal_f}, 5'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Directed cases on both builds
        issue(16'h1234, 16'h1234, 1'b0, 1'b1, 1'b1); wait_idle();
        issue(16'h8000, 16'h7FFF, 1'b0, 1'b1, 1'b1); wait_idle();
        issue(16'h8000, 16'h7FFF, 1'b1, 1'b1, 1'b1); wait_idle();
        issue(16'h1230, 16'h1231, 1'b0, 1'b1, 1'b1); wait_idle();
        issue(16'hF000, 16'h0000, 1'b0, 1'b1, 1'b1); wait_idle();
        issue(16'hFFFF, 16'h0001, 1'b1, 1'b1, 1'b1); wait_idle();
        issue(16'h0000, 16'hFFFF, 1'b1, 1'b1, 1'b1); wait_idle();
        issue(16'h0F00, 16'h0E00, 1'b1, 1'b1, 1'b1); wait_idle();

        // Random operands, often sharing upper digits so the exit point varies
        for (int i = 0; i < 24; i++) begin
            ra = WIDTH'($urandom);
            rb = ra ^ (WIDTH'($urandom_range(0, 15)) << (4 * $urandom_range(0, 3)));
            rs = 1'(i % 2);
            issue(ra, rb, rs, 1'b1, 1'b1);
            wait_idle();
        end

        // Start during RUN is ignored and the captured operands stay put
        issue(16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        a = 16'h0000;
        b = 16'hFFFF;
        start_e = 1'b1;
        @(posedge clk);
        #1;
        start_e = 1'b0;
        wait_idle();

        // Start held in the DONE cycle is accepted back-to-back
        issue(16'h00FF, 16'h00FE, 1'b0, 1'b1, 1'b0);
        guard = 0;
        while (!done_e && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("done_seen", done_e, 1'b1);
        a = 16'h0001;
        b = 16'h0100;
        signed_mode = 1'b0;
        start_e = 1'b1;
        push(16'h0001, 16'h0100, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        start_e = 1'b0;
        check("b2b_cleared", {busy_e, less_e, greater_e, equal_e}, 4'b1000);
        wait_idle();

        // Asynchronous reset mid-RUN aborts with no done pulse
        issue(16'h1234, 16'h1234, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort_outs_e", {busy_e, done_e, less_e, greater_e, equal_e}, 5'b0);
        check("abort_outs_f", {busy_f, done_f, less_f, greater_f, equal_f}, 5'b0);
        q_e.delete();
        q_f.delete();
        @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("post_abort_idle", {busy_e, done_e, busy_f, done_f}, 4'b0);
        end
        issue(16'h0010, 16'h0100, 1'b0, 1'b1, 1'b1);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_magnitude_comparator.md
Name: seq_magnitude_comparator

Overview:
Multi-cycle, parametrised magnitude comparator for two WIDTH-bit operands. It compares DIGIT bits per clock, MSB digit first, with optional early exit on the first differing digit. It supports unsigned and two's-complement signed modes and a start/busy/done handshake. It is the datapath-facing successor to the fixed 4-bit combinational comparator and is intended for ALU/branch-condition units where area matters more than latency.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of DIGIT, WIDTH >= DIGIT.
DIGIT, 4, bits compared per cycle; N = WIDTH/DIGIT digit steps.
EARLY_EXIT, 1, 1 = finish at the first differing digit; 0 = always take N steps (fixed latency).

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled on the clock edge, accepted when state != RUN
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
signed_mode  input  1  1 = two's-complement compare; captured on accepted start
busy  output  1  high while state == RUN
done  output  1  one-cycle pulse while state == DONE
less  output  1  A < B, valid from done onward
greater  output  1  A > B, valid from done onward
equal  output  1  A == B, valid from done onward

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, less, greater, equal = 0; operand registers and digit index = 0.
- States: IDLE, RUN, DONE. busy = (state==RUN); done = (state==DONE).
- IDLE/DONE + start at edge k: capture a, b, signed_mode; clear less/greater/equal; index = N-1; state = RUN. A start in DONE is accepted, so back-to-back operations are supported.
- RUN + start: ignored; captured operands are unaffected by input changes.
- RUN, each edge: compare digit[index] of A against digit[index] of B.
  - Signed mode: invert bit WIDTH-1 of both operands before comparing (offset-binary). This applies to the top digit only.
  - Digit differs and no difference recorded yet: record lt/gt.
    - EARLY_EXIT=1: set less/greater, state = DONE.
    - EARLY_EXIT=0: hold the recorded result and continue; later digits never overwrite it.
  - index==0 step: drive the recorded result; if no difference was recorded, equal=1. State = DONE. Otherwise index decrements.
- Latency: first differing digit j (N-1 = MSB digit) finishes at edge k+N-j with EARLY_EXIT=1. The worst case and the EARLY_EXIT=0 case finish at edge k+N. done is high for the single cycle after that edge.
- DONE with no start: next edge state = IDLE.
- Result outputs hold after done until the next accepted start clears them.
- Exactly one of less/greater/equal is high after done; all three are low while RUN.
- Reset asserted mid-RUN aborts the operation with no done pulse. The first start after reset deasserts behaves normally.

Decomposition:
- Shared package cmp_pkg holds:
  - state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - result codes CMP_LT, CMP_GT, CMP_EQ;
  - the N = WIDTH/DIGIT derivation and a width check that errors at elaboration if WIDTH % DIGIT != 0.
- One sub-module: digit_compare (parameter DIGIT). Combinational; inputs x, y [DIGIT]; outputs lt, gt, eq. Instantiated once on the muxed digits.
- FSM, index counter and result registers sit in the top module.

Test Plan:
1. WIDTH=16, DIGIT=4, EARLY_EXIT=1, unsigned, a=0x1234, b=0x1234, start at edge k -> busy during edges k..k+3; done in the cycle after edge k+4; equal=1, less=greater=0.
2. Unsigned a=0x8000, b=0x7FFF -> greater=1, done after edge k+1. Same operands with signed_mode=1 -> less=1, done after edge k+1.
3. Unsigned a=0x1230, b=0x1231 -> less=1 at edge k+4. Rebuild with EARLY_EXIT=0; a=0xF000, b=0x0000 -> greater=1, done still after edge k+4 (fixed latency).
4. Signed a=0xFFFF (-1), b=0x0001 -> less=1. Then a=0x0000, b=0xFFFF -> greater=1.
5. Handshake: start pulsed at k+2 during RUN with different a/b -> ignored, original result reported. Start held high in the DONE cycle with new operands -> accepted, results clear to 0, new compare completes correctly.
6. Assert reset asynchronously mid-RUN (between edges) -> all outputs 0 immediately, no done pulse. Deassert, start a=0x0010, b=0x0100 -> less=1 after edge k+2.
